// File: rtl/decode_stage_piped_if.sv
// Bundle between the IF/ID side (master) and the decode stage (slave):
// instruction, write-back, hazard/handshake inputs and the registered ID/EX outputs.
interface decode_stage_piped_if #(
    parameter int DATA_WIDTH = 32,
    parameter int NREG       = 32
);
    localparam int RADDR_W = $clog2(NREG);

    logic                  i_valid;
    logic [DATA_WIDTH-1:0] i_instruccion;
    logic [DATA_WIDTH-1:0] i_currentpc;
    logic                  i_wb_write;
    logic [RADDR_W-1:0]    i_wb_addr;
    logic [DATA_WIDTH-1:0] i_wb_data;
    logic                  i_ex_memread;
    logic [RADDR_W-1:0]    i_ex_rt;
    logic                  i_ex_ready;
    logic                  i_flush;

    logic                  o_stall;
    logic                  o_valid;
    logic [DATA_WIDTH-1:0] o_regA;
    logic [DATA_WIDTH-1:0] o_regB;
    logic [DATA_WIDTH-1:0] o_extendido;
    logic [DATA_WIDTH-1:0] o_pcbranch;
    logic [RADDR_W-1:0]    o_rs;
    logic [RADDR_W-1:0]    o_rt;
    logic [RADDR_W-1:0]    o_rd;
    logic [3:0]            o_ex;
    logic [2:0]            o_mem;
    logic [1:0]            o_wb;

    modport master (
        output i_valid, i_instruccion, i_currentpc, i_wb_write, i_wb_addr, i_wb_data,
               i_ex_memread, i_ex_rt, i_ex_ready, i_flush,
        input  o_stall, o_valid, o_regA, o_regB, o_extendido, o_pcbranch,
               o_rs, o_rt, o_rd, o_ex, o_mem, o_wb
    );

    modport slave (
        input  i_valid, i_instruccion, i_currentpc, i_wb_write, i_wb_addr, i_wb_data,
               i_ex_memread, i_ex_rt, i_ex_ready, i_flush,
        output o_stall, o_valid, o_regA, o_regB, o_extendido, o_pcbranch,
               o_rs, o_rt, o_rd, o_ex, o_mem, o_wb
    );
endinterface

// File: rtl/decode_stage_piped.sv
// Registered MIPS decode stage: register bank, sign extend, branch adder, control decode, load-use hazard.
// Optional macro DECODE_WB_BYPASS_EN forwards write-back data into the operand reads in the same cycle.
module decode_stage_piped #(
    parameter int DATA_WIDTH = 32,
    parameter int NREG       = 32
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    decode_stage_piped_if.slave  bus
);
    localparam int RADDR_W = $clog2(NREG);

    typedef enum logic {RUN, STALL} state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] regs_q [NREG];

    logic                  valid_q;
    logic [3:0]            ex_q;
    logic [2:0]            mem_q;
    logic [1:0]            wb_q;
    logic [DATA_WIDTH-1:0] regA_q, regB_q, ext_q, pcBranch_q;
    logic [RADDR_W-1:0]    rs_q, rt_q, rd_q;

    logic [5:0]            opcode;
    logic [RADDR_W-1:0]    rs, rt, rd;
    logic [DATA_WIDTH-1:0] ext, pcBranch, regA, regB;
    logic                  isR, isLw, isSw, isBeq, isAddi;
    logic [3:0]            exCtl;
    logic [2:0]            memCtl;
    logic [1:0]            wbCtl;
    logic                  wbEn, loadUse, wbConflict, hz;
    logic                  load, bubble, stall;

    assign opcode   = bus.i_instruccion[31:26];
    assign rs       = bus.i_instruccion[21 +: RADDR_W];
    assign rt       = bus.i_instruccion[16 +: RADDR_W];
    assign rd       = bus.i_instruccion[11 +: RADDR_W];
    assign ext      = {{(DATA_WIDTH-16){bus.i_instruccion[15]}}, bus.i_instruccion[15:0]};
    assign pcBranch = bus.i_currentpc + {ext[DATA_WIDTH-3:0], 2'b00};
    assign wbEn     = bus.i_wb_write && (bus.i_wb_addr != '0);

    assign isR    = (opcode == 6'h00);
    assign isLw   = (opcode == 6'h23);
    assign isSw   = (opcode == 6'h2B);
    assign isBeq  = (opcode == 6'h04);
    assign isAddi = (opcode == 6'h08);
    // ex = {RegDst, ALUOp[1:0], ALUSrc}, mem = {Branch, MemRead, MemWrite}, wb = {RegWrite, MemtoReg}
    assign exCtl  = {isR, isR, isBeq, isLw | isSw | isAddi};
    assign memCtl = {isBeq, isLw, isSw};
    assign wbCtl  = {isR | isLw | isAddi, isLw};

    always_comb begin
        regA = (rs == '0) ? '0 : regs_q[rs];
        regB = (rt == '0) ? '0 : regs_q[rt];
`ifdef DECODE_WB_BYPASS_EN
        if (wbEn && (bus.i_wb_addr == rs)) regA = bus.i_wb_data;
        if (wbEn && (bus.i_wb_addr == rt)) regB = bus.i_wb_data;
`endif
    end

    // While in STALL the instruction in EX is our own bubble, so the load-use term cannot re-trigger.
    assign loadUse = (state_q == RUN) && bus.i_ex_memread && (bus.i_ex_rt != '0) &&
                     ((bus.i_ex_rt == rs) || (bus.i_ex_rt == rt));
`ifdef DECODE_WB_BYPASS_EN
    assign wbConflict = 1'b0;
`else
    assign wbConflict = wbEn && ((bus.i_wb_addr == rs) || (bus.i_wb_addr == rt));
`endif
    assign hz = bus.i_valid && (loadUse || wbConflict);

    // Priority: flush, then backpressure, then hazard.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        bubble  = 1'b0;
        stall   = 1'b0;
        if (bus.i_flush) begin
            state_d = RUN;
            load    = 1'b1;
            bubble  = 1'b1;
        end else if (!bus.i_ex_ready) begin
            stall = 1'b1;
        end else begin
            load    = 1'b1;
            bubble  = hz || !bus.i_valid;
            stall   = hz;
            state_d = hz ? STALL : RUN;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
        end else if (wbEn) begin
            regs_q[bus.i_wb_addr] <= bus.i_wb_data;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q    <= RUN;
            valid_q    <= 1'b0;
            ex_q       <= '0;
            mem_q      <= '0;
            wb_q       <= '0;
            regA_q     <= '0;
            regB_q     <= '0;
            ext_q      <= '0;
            pcBranch_q <= '0;
            rs_q       <= '0;
            rt_q       <= '0;
            rd_q       <= '0;
        end else begin
            state_q <= state_d;
            if (load) begin
                valid_q    <= !bubble;
                ex_q       <= bubble ? 4'b0 : exCtl;
                mem_q      <= bubble ? 3'b0 : memCtl;
                wb_q       <= bubble ? 2'b0 : wbCtl;
                regA_q     <= regA;
                regB_q     <= regB;
                ext_q      <= ext;
                pcBranch_q <= pcBranch;
                rs_q       <= rs;
                rt_q       <= rt;
                rd_q       <= rd;
            end
        end
    end

    assign bus.o_stall     = stall;
    assign bus.o_valid     = valid_q;
    assign bus.o_ex        = ex_q;
    assign bus.o_mem       = mem_q;
    assign bus.o_wb        = wb_q;
    assign bus.o_regA      = regA_q;
    assign bus.o_regB      = regB_q;
    assign bus.o_extendido = ext_q;
    assign bus.o_pcbranch  = pcBranch_q;
    assign bus.o_rs        = rs_q;
    assign bus.o_rt        = rt_q;
    assign bus.o_rd        = rd_q;
endmodule

// File: tb/tb_decode_stage_piped.sv
// Self-checking bench for decode_stage_piped: directed scenarios plus randomized traffic
// checked against a cycle-level reference model of the decode rules.
module tb_decode_stage_piped;
    logic clk  = 1'b0;
    logic rstN = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    decode_stage_piped_if #(.DATA_WIDTH(32), .NREG(32)) bus ();
    decode_stage_piped #(.DATA_WIDTH(32), .NREG(32)) dut (
        .i_clock(clk),
        .i_reset(rstN),
        .bus    (bus)
    );

    // Reference model state.
    logic [31:0] refRegs [32];
    logic        inStall;
    logic        expStall, expValid;
    logic [8:0]  expCtl;
    logic [31:0] expA, expB, expExt, expPcb;
    logic [4:0]  expRs, expRt, expRd;
    logic        take, nValid, nHz;
    logic [8:0]  nCtl;
    logic [31:0] nA, nB, nExt, nPcb;
    logic [4:0]  nRs, nRt, nRd;
    logic        pWbW;
    logic [4:0]  pWbA;
    logic [31:0] pWbD;

    function automatic logic [8:0] ctrlFor(input logic [5:0] op);
        case (op)
            6'h00:   return 9'b1100_000_10;
            6'h23:   return 9'b0001_010_11;
            6'h2B:   return 9'b0001_001_00;
            6'h04:   return 9'b0010_100_00;
            6'h08:   return 9'b0001_000_10;
            default: return 9'b0;
        endcase
    endfunction

    function automatic logic [31:0] rtype(input logic [4:0] s, input logic [4:0] t, input logic [4:0] d);
        return {6'h00, s, t, d, 5'd0, 6'h20};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] s, input logic [4:0] t,
                                          input logic [15:0] imm);
        return {op, s, t, imm};
    endfunction

    function automatic logic [31:0] readRef(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
`ifdef DECODE_WB_BYPASS_EN
        if (pWbW && pWbA == a) return pWbD;
`endif
        return refRegs[a];
    endfunction

    task automatic modelClear();
        for (int i = 0; i < 32; i++) refRegs[i] = 32'd0;
        inStall  = 1'b0;
        expValid = 1'b0;
        expCtl   = 9'd0;
        {expA, expB, expExt, expPcb} = '0;
        {expRs, expRt, expRd} = '0;
    endtask

    task automatic setInputs(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                             input logic wbW, input logic [4:0] wbA, input logic [31:0] wbD,
                             input logic mr, input logic [4:0] exRt, input logic rdy, input logic fl);
        bus.i_valid = v;        bus.i_instruccion = instr; bus.i_currentpc = pc;
        bus.i_wb_write = wbW;   bus.i_wb_addr = wbA;       bus.i_wb_data = wbD;
        bus.i_ex_memread = mr;  bus.i_ex_rt = exRt;        bus.i_ex_ready = rdy;
        bus.i_flush = fl;
    endtask

    task automatic applyStimulus(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                                 input logic wbW, input logic [4:0] wbA, input logic [31:0] wbD,
                                 input logic mr, input logic [4:0] exRt, input logic rdy, input logic fl);
        @(negedge clk);
        setInputs(v, instr, pc, wbW, wbA, wbD, mr, exRt, rdy, fl);
        #1;
    endtask

    // Evaluates the decode rules on the inputs currently driven.
    task automatic predict();
        logic [4:0] s, t;
        logic ld, wbHit;
        pWbW = bus.i_wb_write && bus.i_wb_addr != 5'd0;
        pWbA = bus.i_wb_addr;
        pWbD = bus.i_wb_data;
        s = bus.i_instruccion[25:21];
        t = bus.i_instruccion[20:16];
        ld = bus.i_ex_memread && bus.i_ex_rt != 5'd0 && (bus.i_ex_rt == s || bus.i_ex_rt == t);
        wbHit = 1'b0;
`ifndef DECODE_WB_BYPASS_EN
        wbHit = pWbW && (pWbA == s || pWbA == t);
`endif
        nHz = bus.i_valid && (ld || wbHit);
        if (bus.i_flush) begin
            expStall = 1'b0; take = 1'b1; nValid = 1'b0;
        end else if (!bus.i_ex_ready) begin
            expStall = 1'b1; take = 1'b0; nValid = 1'b0;
        end else begin
            expStall = nHz; take = 1'b1; nValid = bus.i_valid && !nHz;
        end
        nCtl = nValid ? ctrlFor(bus.i_instruccion[31:26]) : 9'd0;
        nA   = readRef(s);
        nB   = readRef(t);
        nExt = {{16{bus.i_instruccion[15]}}, bus.i_instruccion[15:0]};
        nPcb = bus.i_currentpc + nExt * 32'd4;
        nRs = s; nRt = t; nRd = bus.i_instruccion[15:11];
    endtask

    task automatic advance();
        logic fl, rdy;
        fl  = bus.i_flush;
        rdy = bus.i_ex_ready;
        @(posedge clk);
        if (take) begin
            expValid = nValid; expCtl = nCtl;
            expA = nA; expB = nB; expExt = nExt; expPcb = nPcb;
            expRs = nRs; expRt = nRt; expRd = nRd;
        end
        if (pWbW) refRegs[pWbA] = pWbD;
        if (fl) inStall = 1'b0;
        else if (rdy) inStall = nHz;
        #1;
    endtask

    task automatic resetAssert();
        @(negedge clk);
        setInputs(0, 32'd0, 32'd0, 0, 5'd0, 32'd0, 0, 5'd0, 1, 0);
        #1 rstN = 1'b0;
        modelClear();
        #1;
    endtask

    task automatic test_reset();
        setInputs(0, 32'd0, 32'd0, 0, 5'd0, 32'd0, 0, 5'd0, 1, 0);
        modelClear();
        #12;
        checks++;
        if (bus.o_valid !== 1'b0 || bus.o_regA !== 32'd0 || bus.o_pcbranch !== 32'd0 ||
            {bus.o_ex, bus.o_mem, bus.o_wb} !== 9'd0 || bus.o_rd !== 5'd0) begin
            errors++;
            $display("[TB] FAIL power-on reset: valid=%b regA=%h ctl=%b expected all zero",
                     bus.o_valid, bus.o_regA, {bus.o_ex, bus.o_mem, bus.o_wb});
        end
        @(negedge clk) rstN = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            applyStimulus(0, 32'd0, 32'd0, 1, 5'(i), 32'h100 + i, 0, 5'd0, 1, 0);
            predict(); advance();
        end
        applyStimulus(1, rtype(5'd1, 5'd2, 5'd3), 32'h40, 0, 5'd0, 32'd0, 0, 5'd0, 1, 0);
        predict(); advance();
        checks++;
        if (bus.o_valid !== 1'b1 || bus.o_regA !== 32'h101) begin
            errors++;
            $display("[TB] FAIL pre-reset issue: valid=%b regA=%h expected 1 / 00000101", bus.o_valid, bus.o_regA);
        end
        resetAssert();
        checks++;
        if (bus.o_valid !== 1'b0 || bus.o_regA !== 32'd0 || bus.o_wb !== 2'd0 || bus.o_rd !== 5'd0) begin
            errors++;
            $display("[TB] FAIL mid-run reset: valid=%b regA=%h wb=%b rd=%0d expected zeros",
                     bus.o_valid, bus.o_regA, bus.o_wb, bus.o_rd);
        end
        @(negedge clk) rstN = 1'b1;
        for (int i = 1; i < 32; i++) begin
            applyStimulus(1, rtype(5'(i), 5'(i), 5'd0), 32'd0, 0, 5'd0, 32'd0, 0, 5'd0, 1, 0);
            predict(); advance();
            checks++;
            if (bus.o_regA !== 32'd0 || bus.o_regB !== 32'd0) begin
                errors++;
                $display("[TB] FAIL reg cleared r%0d: got %h/%h expected 0", i, bus.o_regA, bus.o_regB);
            end
        end
        // Reset while stalled, then the same hazard must stall again from RUN.
        applyStimulus(1, rtype(5'd4, 5'd0, 5'd5), 32'd0, 0, 5'd0, 32'd0, 1, 5'd4, 1, 0);
        predict(); advance();
        resetAssert();
        @(negedge clk);
        rstN = 1'b1;
        setInputs(1, rtype(5'd4, 5'd0, 5'd5), 32'd0, 0, 5'd0, 32'd0, 1, 5'd4, 1, 0);
        #1;
        predict();
        checks++;
        if (bus.o_stall !== 1'b1 || bus.o_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset in STALL: stall=%b valid=%b expected 1/0", bus.o_stall, bus.o_valid);
        end
        advance();
        applyStimulus(1, rtype(5'd4, 5'd0, 5'd5), 32'd0, 0, 5'd0, 32'd0, 0, 5'd0, 1, 0);
        predict(); advance();
        checks++;
        if (bus.o_valid !== 1'b1 || bus.o_rd !== 5'd5) begin
            errors++;
            $display("[TB] FAIL issue after reset stall: valid=%b rd=%0d expected 1/5", bus.o_valid, bus.o_rd);
        end
    endtask

    task automatic test_straight_line();
        applyStimulus(0, 32'd0, 32'd0, 1, 5'd1, 32'd5, 0, 5'd0, 1, 0); predict(); advance();
        applyStimulus(0, 32'd0, 32'd0, 1, 5'd2, 32'd7, 0, 5'd0, 1, 0); predict(); advance();
        applyStimulus(1, rtype(5'd1, 5'd2, 5'd3), 32'h10, 0, 5'd0, 32'd0, 0, 5'd0, 1, 0);
        predict();
        checks++;
        if (bus.o_stall !== 1'b0) begin
            errors++;
            $display("[TB] FAIL add stall: got %b expected 0", bus.o_stall);
        end
        advance();
        checks++;
        if (bus.o_valid !== 1'b1 || bus.o_regA !== 32'd5 || bus.o_regB !== 32'd7 || bus.o_rd !== 5'd3 ||
            bus.o_ex !== 4'b1100 || bus.o_wb !== 2'b10 || bus.o_pcbranch !== 32'h6090) begin
            errors++;
            $display("[TB] FAIL add bundle: valid=%b A=%h B=%h rd=%0d ex=%b wb=%b pcb=%h expected 1 5 7 3 1100 10 6090",
                     bus.o_valid, bus.o_regA, bus.o_regB, bus.o_rd, bus.o_ex, bus.o_wb, bus.o_pcbranch);
        end
    endtask

    task automatic test_load_use();
        applyStimulus(0, 32'd0, 32'd0, 1, 5'd4, 32'h44, 0, 5'd0, 1, 0); predict(); advance();
        applyStimulus(0, 32'd0, 32'd0, 1, 5'd6, 32'h66, 0, 5'd0, 1, 0); predict(); advance();
        applyStimulus(1, rtype(5'd4, 5'd6, 5'd5), 32'h20, 0, 5'd0, 32'd0, 1, 5'd4, 1, 0);
        predict();
        checks++;
        if (bus.o_stall !== 1'b1) begin
            errors++;
            $display("[TB] FAIL load-use stall: got %b expected 1", bus.o_stall);
        end
        advance();
        checks++;
        if (bus.o_valid !== 1'b0 || {bus.o_ex, bus.o_mem, bus.o_wb} !== 9'd0) begin
            errors++;
            $display("[TB] FAIL load-use bubble: valid=%b ctl=%b expected 0/0", bus.o_valid,
                     {bus.o_ex, bus.o_mem, bus.o_wb});
        end
        applyStimulus(1, rtype(5'd4, 5'd6, 5'd5), 32'h20, 0, 5'd0, 32'd0, 0, 5'd0, 1, 0);
        predict();
        checks++;
        if (bus.o_stall !== 1'b0) begin
            errors++;
            $display("[TB] FAIL load-use release stall: got %b expected 0", bus.o_stall);
        end
        advance();
        checks++;
        if (bus.o_valid !== 1'b1 || bus.o_regA !== 32'h44 || bus.o_regB !== 32'h66 || bus.o_rd !== 5'd5) begin
            errors++;
            $display("[TB] FAIL load-use reissue: valid=%b A=%h B=%h rd=%0d expected 1 44 66 5",
                     bus.o_valid, bus.o_regA, bus.o_regB, bus.o_rd);
        end
        applyStimulus(1, rtype(5'd0, 5'd6, 5'd7), 32'h24, 0, 5'd0, 32'd0, 1, 5'd0, 1, 0);
        predict();
        checks++;
        if (bus.o_stall !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ex_rt zero stall: got %b expected 0", bus.o_stall);
        end
        advance();
    endtask

    task automatic test_flush_backpressure();
        applyStimulus(1, itype(6'h08, 5'd4, 5'd9, 16'h0012), 32'h30, 0, 5'd0, 32'd0, 0, 5'd0, 1, 0);
        predict(); advance();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, rtype(5'd6, 5'd6, 5'd10), 32'h34, 0, 5'd0, 32'd0, 0, 5'd0, 0, 0);
            predict();
            checks++;
            if (bus.o_stall !== 1'b1) begin
                errors++;
                $display("[TB] FAIL backpressure stall %0d: got %b expected 1", i, bus.o_stall);
            end
            advance();
            checks++;
            if (bus.o_valid !== 1'b1 || bus.o_rt !== 5'd9 || bus.o_regA !== 32'h44 || bus.o_wb !== 2'b10) begin
                errors++;
                $display("[TB] FAIL backpressure hold %0d: valid=%b rt=%0d A=%h wb=%b expected 1 9 44 10",
                         i, bus.o_valid, bus.o_rt, bus.o_regA, bus.o_wb);
            end
        end
        applyStimulus(1, rtype(5'd6, 5'd6, 5'd10), 32'h34, 0, 5'd0, 32'd0, 1, 5'd6, 0, 1);
        predict();
        checks++;
        if (bus.o_stall !== 1'b0) begin
            errors++;
            $display("[TB] FAIL flush stall: got %b expected 0", bus.o_stall);
        end
        advance();
        checks++;
        if (bus.o_valid !== 1'b0 || {bus.o_ex, bus.o_mem, bus.o_wb} !== 9'd0) begin
            errors++;
            $display("[TB] FAIL flush bundle: valid=%b ctl=%b expected 0/0", bus.o_valid,
                     {bus.o_ex, bus.o_mem, bus.o_wb});
        end
    endtask

    task automatic test_bypass();
        applyStimulus(1, rtype(5'd8, 5'd0, 5'd11), 32'h50, 1, 5'd8, 32'hDEAD, 0, 5'd0, 1, 0);
        predict();
`ifdef DECODE_WB_BYPASS_EN
        checks++;
        if (bus.o_stall !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bypass stall: got %b expected 0", bus.o_stall);
        end
        advance();
`else
        checks++;
        if (bus.o_stall !== 1'b1) begin
            errors++;
            $display("[TB] FAIL wb conflict stall: got %b expected 1", bus.o_stall);
        end
        advance();
        checks++;
        if (bus.o_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL wb conflict bubble: valid=%b expected 0", bus.o_valid);
        end
        applyStimulus(1, rtype(5'd8, 5'd0, 5'd11), 32'h50, 0, 5'd0, 32'd0, 0, 5'd0, 1, 0);
        predict(); advance();
`endif
        checks++;
        if (bus.o_valid !== 1'b1 || bus.o_regA !== 32'hDEAD) begin
            errors++;
            $display("[TB] FAIL bypass value: valid=%b A=%h expected 1 0000dead", bus.o_valid, bus.o_regA);
        end
    endtask

    task automatic test_branch_r0();
        applyStimulus(1, itype(6'h04, 5'd0, 5'd0, 16'hFFFF), 32'h100, 0, 5'd0, 32'd0, 0, 5'd0, 1, 0);
        predict(); advance();
        checks++;
        if (bus.o_extendido !== 32'hFFFF_FFFF || bus.o_pcbranch !== 32'h0000_00FC || bus.o_mem !== 3'b100) begin
            errors++;
            $display("[TB] FAIL beq: ext=%h pcb=%h mem=%b expected ffffffff 000000fc 100",
                     bus.o_extendido, bus.o_pcbranch, bus.o_mem);
        end
        applyStimulus(1, itype(6'h04, 5'd0, 5'd0, 16'h0002), 32'hFFFF_FFFC, 0, 5'd0, 32'd0, 0, 5'd0, 1, 0);
        predict(); advance();
        checks++;
        if (bus.o_pcbranch !== 32'h0000_0004) begin
            errors++;
            $display("[TB] FAIL pcbranch wrap: got %h expected 00000004", bus.o_pcbranch);
        end
        applyStimulus(0, 32'd0, 32'd0, 1, 5'd0, 32'h55, 0, 5'd0, 1, 0); predict(); advance();
        applyStimulus(1, rtype(5'd0, 5'd0, 5'd1), 32'd0, 0, 5'd0, 32'd0, 0, 5'd0, 1, 0);
        predict(); advance();
        checks++;
        if (bus.o_regA !== 32'd0 || bus.o_regB !== 32'd0) begin
            errors++;
            $display("[TB] FAIL r0 write ignored: got %h/%h expected 0", bus.o_regA, bus.o_regB);
        end
    endtask

    task automatic test_random();
        logic [5:0] ops [6];
        logic [5:0] op;
        ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h3F};
        for (int n = 0; n < 400; n++) begin
            op = ops[$urandom_range(0, 5)];
            if ($urandom_range(0, 7) == 0) op = 6'($urandom);
            applyStimulus($urandom_range(0, 3) != 0,
                          {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom)},
                          $urandom, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                          !inStall && ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)),
                          $urandom_range(0, 4) != 0, $urandom_range(0, 9) == 0);
            predict();
            checks++;
            if (bus.o_stall !== expStall) begin
                errors++;
                $display("[TB] FAIL rand stall @%0d: got %b expected %b", n, bus.o_stall, expStall);
            end
            advance();
            checks++;
            if (bus.o_valid !== expValid || {bus.o_ex, bus.o_mem, bus.o_wb} !== expCtl) begin
                errors++;
                $display("[TB] FAIL rand ctl @%0d: valid=%b ctl=%b expected %b %b", n, bus.o_valid,
                         {bus.o_ex, bus.o_mem, bus.o_wb}, expValid, expCtl);
            end
            if (expValid) begin
                checks++;
                if (bus.o_regA !== expA || bus.o_regB !== expB || bus.o_extendido !== expExt ||
                    bus.o_pcbranch !== expPcb || bus.o_rs !== expRs || bus.o_rt !== expRt || bus.o_rd !== expRd) begin
                    errors++;
                    $display("[TB] FAIL rand data @%0d: A=%h B=%h ext=%h pcb=%h expected %h %h %h %h",
                             n, bus.o_regA, bus.o_regB, bus.o_extendido, bus.o_pcbranch, expA, expB, expExt, expPcb);
                end
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        test_reset();
        test_straight_line();
        test_load_use();
        test_flush_backpressure();
        test_bypass();
        test_branch_r0();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
